// File: rtl/count_run_controller.sv
// Run-control FSM and prescaler for the 8-bit display counter. `define COUNT_AUTO_RELOAD_EN enables periodic reload mode.
// Latency: counter/state/done are registered (1 cycle after the strobe or tick); tick is combinational from state and prescaler.
// Backpressure: none; start/pause/stop are single-cycle strobes with priority stop > pause > start.
module count_run_controller #(
  parameter int DIV     = 25_000_000,
  parameter int PRESC_W = 25
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  input  logic         dir_up,
  input  logic [7:0]   load_val,
  input  logic [7:0]   limit,
  output logic [7:0]   counter,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [7:0]           counter_d;
  logic                 done_d;

  assign tick  = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign state = state_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      counter <= 8'd0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      counter <= counter_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    counter_d = counter;
    done_d    = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_RUN;
            presc_d   = '0;
            counter_d = load_val;
          end
        end
        S_RUN: begin
          // Pause freezes the prescaler, so a coinciding tick is replayed on resume.
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
              if (counter == limit) begin
                done_d = 1'b1;
`ifdef COUNT_AUTO_RELOAD_EN
                counter_d = load_val;
`else
                state_d = S_DONE;
`endif
              end else if (dir_up) begin
                counter_d = counter + 8'd1;
              end else begin
                counter_d = counter - 8'd1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (start && !pause) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_run_controller.sv
// Directed bench for count_run_controller with DIV=4; expected values are hand-computed per step.
module tb_count_run_controller;

  logic       clk_in = 1'b0;
  logic       reset, start, pause, stop, dir_up;
  logic [7:0] load_val, limit, counter;
  logic       tick, busy, done;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  count_run_controller #(.DIV(4), .PRESC_W(3)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .dir_up(dir_up), .load_val(load_val), .limit(limit), .counter(counter),
    .tick(tick), .busy(busy), .done(done), .state(state)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic go(input logic [7:0] lv, input logic [7:0] lim, input logic up);
    load_val = lv; limit = lim; dir_up = up; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; dir_up = 1'b1;
    load_val = 8'd0; limit = 8'd0;
    #3;
    chk("rst_counter", counter, 0);
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step(1);
    reset = 1'b0;
    step(1);

    // Count up 3..6 then terminal tick
    go(8'd3, 8'd6, 1'b1);
    chk("t1_load", counter, 3);
    chk("t1_state_run", state, 1);
    chk("t1_busy", busy, 1);
    chk("t1_tick0", tick, 0);
    step(3);
    chk("t1_first_tick", tick, 1);
    step(1);
    chk("t1_c4", counter, 4);
    chk("t1_tick_low", tick, 0);
    step(4);
    chk("t1_c5", counter, 5);
    step(4);
    chk("t1_c6", counter, 6);
    step(4);
    chk("t1_done", done, 1);
    chk("t1_state_done", state, 3);
    chk("t1_hold", counter, 6);
    chk("t1_busy_done", busy, 0);
    step(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_state_done2", state, 3);

    // Count down with wrap 1,0,255,254
    go(8'd1, 8'd254, 1'b0);
    chk("t2_load", counter, 1);
    step(4);
    chk("t2_c0", counter, 0);
    step(4);
    chk("t2_c255", counter, 255);
    step(4);
    chk("t2_c254", counter, 254);
    step(4);
    chk("t2_done", done, 1);
    chk("t2_state", state, 3);
    chk("t2_hold", counter, 254);

    // Pause at presc=2, then pause on a tick cycle
    go(8'd10, 8'd200, 1'b1);
    step(2);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk("t3_state_pause", state, 2);
    chk("t3_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_no_tick", tick, 0);
      chk("t3_frozen", counter, 10);
      step(1);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t3_resume", state, 1);
    chk("t3_resume_tick0", tick, 0);
    step(1);
    chk("t3_resume_tick", tick, 1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk("t3_tick_discard", counter, 10);
    chk("t3_state_pause2", state, 2);
    chk("t3_pause_tick", tick, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t3_replay_tick", tick, 1);
    step(1);
    chk("t3_c11", counter, 11);

    // All strobes together: stop wins
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    step(1);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    chk("t4_state", state, 0);
    chk("t4_hold", counter, 11);
    chk("t4_busy", busy, 0);
    step(5);
    chk("t4_hold2", counter, 11);
    chk("t4_tick", tick, 0);

    // Async reset mid-run
    go(8'd50, 8'd60, 1'b1);
    step(2);
    #2 reset = 1'b1;
    #1;
    chk("t5_counter", counter, 0);
    chk("t5_state", state, 0);
    chk("t5_tick", tick, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    #1 reset = 1'b0;
    step(1);
    chk("t5_done_after", done, 0);
    chk("t5_state_after", state, 0);

`ifdef COUNT_AUTO_RELOAD_EN
    // Periodic mode 3,4,5,(done)3,4
    go(8'd3, 8'd5, 1'b1);
    chk("t6_load", counter, 3);
    step(4);
    chk("t6_c4", counter, 4);
    step(4);
    chk("t6_c5", counter, 5);
    step(4);
    chk("t6_done", done, 1);
    chk("t6_reload", counter, 3);
    chk("t6_state", state, 1);
    step(4);
    chk("t6_c4b", counter, 4);
    chk("t6_done_low", done, 0);
    chk("t6_state2", state, 1);
`else
    // load_val == limit terminates on first tick
    go(8'd7, 8'd7, 1'b1);
    chk("t6_load", counter, 7);
    step(3);
    chk("t6_tick", tick, 1);
    step(1);
    chk("t6_done", done, 1);
    chk("t6_state", state, 3);
    chk("t6_hold", counter, 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
